// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Holds the FSM state encoding, the stall-vector bit positions used by the PC
// register and the if_id / id_ex pipeline registers, and the datapath widths.
package pipe_ctrl_pkg;

  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned StallWidth = 3;
  localparam int unsigned CntWidth   = 32;

  // Bit positions inside stall_o.
  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IF_ID = 1;
  localparam int unsigned STALL_ID_EX = 2;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StHoldEx  = 2'd2,
    StHoldMem = 2'd3
  } pipe_state_e;

  function automatic logic [StallWidth-1:0] stall_mask(input logic pc,
                                                       input logic if_id,
                                                       input logic id_ex);
    logic [StallWidth-1:0] m;
    m              = '0;
    m[STALL_PC]    = pc;
    m[STALL_IF_ID] = if_id;
    m[STALL_ID_EX] = id_ex;
    return m;
  endfunction

  localparam logic [StallWidth-1:0] StallNone  = '0;
  // Front of the pipe frozen, execute keeps computing its multi-cycle op.
  localparam logic [StallWidth-1:0] StallFront = stall_mask(1'b1, 1'b1, 1'b0);
  // Whole pipe frozen while data memory is not ready.
  localparam logic [StallWidth-1:0] StallAll   = stall_mask(1'b1, 1'b1, 1'b1);

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with enable.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, clears the count
//   en_i   - count enable; the count holds when low or when already at all-ones
//   cnt_o  - current count
module pipe_ctrl_sat_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the three-stage fetch/decode/execute core.
// Turns execute-stage redirect/hold requests and the data-memory wait line into
// PC-redirect, per-stage stall and flush controls.
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   jump_en_i       - execute-stage redirect request
//   jump_addr_i     - redirect target
//   hold_ex_i       - execute stage needs another cycle
//   mem_wait_i      - data memory not ready, freeze everything
//   jump_en_o       - PC loads jump_addr_o at the next edge
//   jump_addr_o     - redirect target towards the PC register
//   stall_o         - freeze enables {id_ex, if_id, pc}
//   flush_o         - if_id and id_ex load a bubble at the next edge
//   err_o           - sticky hold-timeout flag
//   stall_cycles_o  - saturating count of cycles with any stall bit set
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_MAX     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_en_i,
  input  logic [AddrWidth-1:0]  jump_addr_i,
  input  logic                  hold_ex_i,
  input  logic                  mem_wait_i,
  output logic                  jump_en_o,
  output logic [AddrWidth-1:0]  jump_addr_o,
  output logic [StallWidth-1:0] stall_o,
  output logic                  flush_o,
  output logic                  err_o,
  output logic [CntWidth-1:0]   stall_cycles_o
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] HoldMax   = 8'(HOLD_MAX);

  pipe_state_e st_d, st_q;
  logic [2:0]  flush_cnt_d, flush_cnt_q;
  logic [7:0]  hold_cnt_d, hold_cnt_q;
  logic        err_d, err_q;
  // Set on timeout; masks hold_ex_i until it has been low for a cycle.
  logic        hold_block_d, hold_block_q;

  logic                  run_eval;
  logic                  jump_en;
  logic [AddrWidth-1:0]  jump_addr;
  logic [StallWidth-1:0] stall;
  logic                  flush;

  always_comb begin
    st_d         = st_q;
    flush_cnt_d  = flush_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    err_d        = err_q;
    hold_block_d = hold_block_q & hold_ex_i;
    run_eval     = 1'b0;
    jump_en      = 1'b0;
    jump_addr    = '0;
    stall        = StallNone;
    flush        = 1'b0;

    unique case (st_q)
      StRun: begin
        run_eval = 1'b1;
      end

      StFlush: begin
        // Wrong-path bubbles: redirect and hold requests are not acted on here.
        flush = 1'b1;
        if (mem_wait_i) begin
          stall = StallAll;
        end else if (flush_cnt_q <= 3'd1) begin
          st_d        = StRun;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end

      StHoldEx: begin
        if (mem_wait_i) begin
          stall = StallAll;
        end else if (hold_ex_i) begin
          stall = StallFront;
          if (({1'b0, hold_cnt_q} + 9'd1) >= {1'b0, HoldMax}) begin
            err_d        = 1'b1;
            st_d         = StRun;
            hold_cnt_d   = '0;
            hold_block_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end else begin
          // Releasing cycle behaves as RUN so the finishing op can redirect.
          hold_cnt_d = '0;
          run_eval   = 1'b1;
        end
      end

      StHoldMem: begin
        if (mem_wait_i) begin
          stall = StallAll;
        end else begin
          run_eval = 1'b1;
        end
      end

      default: begin
        st_d = StRun;
      end
    endcase

    if (run_eval) begin
      if (jump_en_i) begin
        jump_en   = 1'b1;
        jump_addr = jump_addr_i;
        flush     = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          st_d        = StFlush;
          flush_cnt_d = FlushLoad;
        end else begin
          st_d = StRun;
        end
      end else if (mem_wait_i) begin
        stall = StallAll;
        st_d  = StHoldMem;
      end else if (hold_ex_i && !hold_block_q) begin
        stall      = StallFront;
        st_d       = StHoldEx;
        hold_cnt_d = 8'd1;
      end else begin
        st_d = StRun;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= StRun;
      flush_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      err_q        <= 1'b0;
      hold_block_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      flush_cnt_q  <= flush_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      err_q        <= err_d;
      hold_block_q <= hold_block_d;
    end
  end

  // Combinational outputs are forced to their reset values while rst is high,
  // so an asynchronous reset clears them even with requests still asserted.
  always_comb begin
    jump_en_o   = jump_en & ~rst;
    jump_addr_o = rst ? '0 : jump_addr;
    stall_o     = rst ? StallNone : stall;
    flush_o     = flush & ~rst;
  end

  assign err_o = err_q;

  pipe_ctrl_sat_cnt #(
    .Width (CntWidth)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (|stall_o),
    .cnt_o (stall_cycles_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        mem_wait_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  stall_o;
  logic        flush_o;
  logic        err_o;
  logic [31:0] stall_cycles_o;

  int n_cmp = 0;
  int n_mis = 0;

  pipe_ctrl #(
    .FLUSH_CYCLES (2),
    .HOLD_MAX     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .hold_ex_i      (hold_ex_i),
    .mem_wait_i     (mem_wait_i),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .err_o          (err_o),
    .stall_cycles_o (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic j, input logic [31:0] a, input logic h, input logic m);
    jump_en_i   = j;
    jump_addr_i = a;
    hold_ex_i   = h;
    mem_wait_i  = m;
  endtask

  // Called just after a falling edge; no rising edge falls inside the pulse.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("rst_jump_en", 32'(jump_en_o), 32'd0);
    chk("rst_jump_addr", jump_addr_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_stall_cnt", stall_cycles_o, 32'd0);

    // Reset in the middle of HOLD_EX, hold request still asserted.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1 chk("holdA_c1_stall", 32'(stall_o), 32'h3);
    @(negedge clk);
    #1 chk("holdA_c2_stall", 32'(stall_o), 32'h3);
    chk("holdA_cnt1", stall_cycles_o, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_flush", 32'(flush_o), 32'd0);
    chk("midrst_jump_en", 32'(jump_en_o), 32'd0);
    chk("midrst_cnt", stall_cycles_o, 32'd0);
    chk("midrst_err", 32'(err_o), 32'd0);
    chk("midrst_state", 32'(dut.st_q), 32'(StRun));
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Redirect with FLUSH_CYCLES=2; second-cycle jump request is ignored.
    @(negedge clk);
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0);
    #1;
    chk("jmp_c1_jump_en", 32'(jump_en_o), 32'd1);
    chk("jmp_c1_addr", jump_addr_o, 32'h0000_0100);
    chk("jmp_c1_flush", 32'(flush_o), 32'd1);
    chk("jmp_c1_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    drive(1'b1, 32'h0000_0200, 1'b0, 1'b0);
    #1;
    chk("jmp_c2_jump_en", 32'(jump_en_o), 32'd0);
    chk("jmp_c2_addr", jump_addr_o, 32'd0);
    chk("jmp_c2_flush", 32'(flush_o), 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("jmp_c3_flush", 32'(flush_o), 32'd0);
    chk("jmp_c3_jump_en", 32'(jump_en_o), 32'd0);
    chk("jmp_stall_cnt", stall_cycles_o, 32'd0);

    // Hold three cycles, release with a redirect.
    @(negedge clk);
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      #1 chk($sformatf("hold3_c%0d_stall", i), 32'(stall_o), 32'h3);
      @(negedge clk);
    end
    drive(1'b1, 32'h0000_0040, 1'b0, 1'b0);
    #1;
    chk("hold3_rel_jump_en", 32'(jump_en_o), 32'd1);
    chk("hold3_rel_addr", jump_addr_o, 32'h0000_0040);
    chk("hold3_rel_flush", 32'(flush_o), 32'd1);
    chk("hold3_rel_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("hold3_cnt", stall_cycles_o, 32'd3);
    chk("hold3_flush2", 32'(flush_o), 32'd1);
    @(negedge clk);
    #1 chk("hold3_flush_end", 32'(flush_o), 32'd0);

    // All requests at once: jump wins; memory wait during FLUSH freezes it.
    @(negedge clk);
    do_reset();
    drive(1'b1, 32'h0000_0080, 1'b1, 1'b1);
    #1;
    chk("prio_jump_en", 32'(jump_en_o), 32'd1);
    chk("prio_flush", 32'(flush_o), 32'd1);
    chk("prio_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("flw_c1_stall", 32'(stall_o), 32'h7);
    chk("flw_c1_flush", 32'(flush_o), 32'd1);
    @(negedge clk);
    #1;
    chk("flw_c2_stall", 32'(stall_o), 32'h7);
    chk("flw_c2_flush", 32'(flush_o), 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("flw_c3_stall", 32'(stall_o), 32'd0);
    chk("flw_c3_flush", 32'(flush_o), 32'd1);
    @(negedge clk);
    #1;
    chk("flw_end_flush", 32'(flush_o), 32'd0);
    chk("flw_cnt", stall_cycles_o, 32'd2);

    // Hold timeout with HOLD_MAX=4.
    @(negedge clk);
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk($sformatf("tmo_c%0d_stall", i), 32'(stall_o), (i <= 4) ? 32'h3 : 32'h0);
      chk($sformatf("tmo_c%0d_err", i), 32'(err_o), (i >= 5) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    #1 chk("tmo_cnt", stall_cycles_o, 32'd4);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("tmo_rearm_stall", 32'(stall_o), 32'h3);
    chk("tmo_err_sticky", 32'(err_o), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();
    #1 chk("tmo_err_cleared", 32'(err_o), 32'd0);

    // Counter saturation.
    @(negedge clk);
    do_reset();
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.u_stall_cnt.cnt_q;
    #1 chk("sat_preload", stall_cycles_o, 32'hFFFF_FFFE);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("sat_c%0d", i), stall_cycles_o, 32'hFFFF_FFFF);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk("sat_hold", stall_cycles_o, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
